stack_sequencer: RTL and testbench

STACK_SEQUENCER -- requirements
Module: stack_sequencer

---
 rtl/stack_pkg.sv | 17 +
 rtl/stack_tick_gen.sv | 53 +++++
 rtl/stack_sequencer.sv | 104 ++++++++++
 tb/tb_stack_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared definitions for the stacker game sequencer: state encoding,
// default playfield height and row index width.
package stack_pkg;

  localparam int NUM_ROWS_DEF = 8;
  localparam int ROW_W        = 3;

  typedef enum logic [2:0] {
    LOAD,
    RUN,
    LOCK,
    NEXT,
    WON,
    LOST
  } state_t;

endpackage

// File: rtl/stack_tick_gen.sv
// Slider tick generator: counts 0..P-1 while enabled and flags the last
// count. With STACK_SPEEDUP_EN defined the period shrinks by TICK_STEP per
// row (floor of 2); otherwise every row uses TICK_BASE.
module stack_tick_gen
  import stack_pkg::*;
#(
  parameter int TICK_BASE = 16,
  parameter int TICK_STEP = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic [ROW_W-1:0] row_sel,
  output logic             tick
);

  localparam int CNT_W = $clog2(TICK_BASE);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] last;

`ifdef STACK_SPEEDUP_EN
  logic [31:0] drop;

  // Last count value of the current row's period, never below a period of 2
  always_comb begin
    drop = 32'(row_sel) * 32'(TICK_STEP);
    last = CNT_W'(1);
    if (drop + 32'd2 < 32'(TICK_BASE)) begin
      last = CNT_W'(32'(TICK_BASE) - drop - 32'd1);
    end
  end
`else
  logic unused_row;

  assign unused_row = (^row_sel) ^ (TICK_STEP < 0);
  assign last       = CNT_W'(TICK_BASE - 1);
`endif

  // Free-running period counter, held at zero whenever the slider is not moving
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr || (count == last)) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign tick = !clr && (count == last);

endmodule

// File: rtl/stack_sequencer.sv
// Control FSM for the stacker game: loads a slider row, moves it on ticks,
// locks it on a button press and walks up the rows until won or lost.
// Optional build macro: STACK_SPEEDUP_EN (faster slider on higher rows).
module stack_sequencer
  import stack_pkg::*;
#(
  parameter int NUM_ROWS  = NUM_ROWS_DEF,
  parameter int TICK_BASE = 16,
  parameter int TICK_STEP = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic             lock_done,
  input  logic             lock_lost,
  output logic             load,
  output logic             shift_en,
  output logic             set,
  output logic [ROW_W-1:0] row_sel,
  output logic             won,
  output logic             lost
);

  state_t state;
  logic   go_q;
  logic   go_rise;
  logic   tick;
  logic   last_row;

  assign go_rise  = go && !go_q;
  assign last_row = (row_sel == ROW_W'(NUM_ROWS - 1));

  stack_tick_gen #(
    .TICK_BASE(TICK_BASE),
    .TICK_STEP(TICK_STEP)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .clr    (state != RUN),
    .row_sel(row_sel),
    .tick   (tick)
  );

  // A press on the very tick cycle must lock, so the move is suppressed here
  assign shift_en = (state == RUN) && tick && !go_rise;

  // Game sequencing; set doubles as the "first LOCK cycle" marker
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= LOAD;
      row_sel <= '0;
      go_q    <= 1'b1;
      load    <= 1'b0;
      set     <= 1'b0;
      won     <= 1'b0;
      lost    <= 1'b0;
    end else begin
      go_q <= go;
      load <= 1'b0;
      set  <= 1'b0;
      case (state)
        LOAD: begin
          load  <= 1'b1;
          state <= RUN;
        end
        RUN: begin
          if (go_rise) begin
            set   <= 1'b1;
            state <= LOCK;
          end
        end
        LOCK: begin
          if (lock_done && !set) begin
            if (lock_lost) begin
              lost  <= 1'b1;
              state <= LOST;
            end else if (last_row) begin
              won   <= 1'b1;
              state <= WON;
            end else begin
              state <= NEXT;
            end
          end
        end
        NEXT: begin
          row_sel <= row_sel + ROW_W'(1);
          state   <= LOAD;
        end
        WON, LOST: begin
          if (go_rise) begin
            won     <= 1'b0;
            lost    <= 1'b0;
            row_sel <= '0;
            state   <= LOAD;
          end
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed testbench for stack_sequencer. Expected tick spacing on the top
// row follows STACK_SPEEDUP_EN when it is defined for the build.
module tb_stack_sequencer;

  localparam int NUM_ROWS  = 8;
  localparam int TICK_BASE = 16;
  localparam int TICK_STEP = 2;
`ifdef STACK_SPEEDUP_EN
  localparam int LAST_PERIOD = 2;
`else
  localparam int LAST_PERIOD = 16;
`endif

  logic       clk       = 1'b0;
  logic       reset     = 1'b0;
  logic       go        = 1'b0;
  logic       lock_done = 1'b0;
  logic       lock_lost = 1'b0;
  logic       load;
  logic       shift_en;
  logic       set;
  logic [2:0] row_sel;
  logic       won;
  logic       lost;

  int checks   = 0;
  int failures = 0;

  stack_sequencer #(
    .NUM_ROWS (NUM_ROWS),
    .TICK_BASE(TICK_BASE),
    .TICK_STEP(TICK_STEP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .go       (go),
    .lock_done(lock_done),
    .lock_lost(lock_lost),
    .load     (load),
    .shift_en (shift_en),
    .set      (set),
    .row_sel  (row_sel),
    .won      (won),
    .lost     (lost)
  );

  // 10 time-unit clock
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Press in RUN, accept lock on the second LOCK cycle, check the outcome
  task automatic lock_row(input logic lost_in, input int row_now);
    string t;
    t = $sformatf("row%0d", row_now);
    go = 1'b1;
    #1;
    check_output({t, "_shift_on_go"}, shift_en, 0);
    @(negedge clk);
    go = 1'b0;
    #1;
    check_output({t, "_set"}, set, 1);
    check_output({t, "_shift_in_lock"}, shift_en, 0);
    @(negedge clk);
    lock_done = 1'b1;
    lock_lost = lost_in;
    #1;
    check_output({t, "_set_one_cycle"}, set, 0);
    @(negedge clk);
    lock_done = 1'b0;
    lock_lost = 1'b0;
    #1;
    if (lost_in) begin
      check_output({t, "_lost"}, lost, 1);
      check_output({t, "_row_kept"}, row_sel, row_now);
    end else if (row_now == NUM_ROWS - 1) begin
      check_output({t, "_won"}, won, 1);
      check_output({t, "_row_top"}, row_sel, row_now);
    end else begin
      check_output({t, "_no_won"}, won, 0);
      check_output({t, "_no_lost"}, lost, 0);
      @(negedge clk);
      #1;
      check_output({t, "_row_inc"}, row_sel, row_now + 1);
      check_output({t, "_load_wait"}, load, 0);
      @(negedge clk);
      #1;
      check_output({t, "_load"}, load, 1);
    end
  endtask

  // Watchdog so the bench always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    // Reset state
    @(negedge clk);
    #1;
    check_output("rst_load", load, 0);
    check_output("rst_shift", shift_en, 0);
    check_output("rst_set", set, 0);
    check_output("rst_won", won, 0);
    check_output("rst_lost", lost, 0);
    check_output("rst_row", row_sel, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Row 0: load on cycle 1, a move every 16 cycles
    for (int k = 1; k <= 47; k++) begin
      @(negedge clk);
      #1;
      if (k == 1) check_output("first_load", load, 1);
      if (k == 2) check_output("load_pulse_end", load, 0);
      check_output($sformatf("r0_shift_k%0d", k), shift_en, (k % 16) == 0);
    end

    // Press on the tick cycle: lock wins over the move
    @(negedge clk);
    go = 1'b1;
    #1;
    check_output("tick_vs_go_shift", shift_en, 0);
    @(negedge clk);
    go        = 1'b0;
    lock_done = 1'b1;
    #1;
    check_output("tick_vs_go_set", set, 1);
    check_output("lock_shift_zero", shift_en, 0);
    @(negedge clk);
    lock_done = 1'b0;
    go        = 1'b1;
    #1;
    check_output("set_single", set, 0);
    @(negedge clk);
    go = 1'b0;
    #1;
    check_output("early_done_ignored", row_sel, 0);
    check_output("lock_wait_load", load, 0);
    @(negedge clk);
    lock_done = 1'b1;
    #1;
    @(negedge clk);
    lock_done = 1'b0;
    #1;
    check_output("next_row_old", row_sel, 0);
    @(negedge clk);
    #1;
    check_output("next_row_new", row_sel, 1);
    @(negedge clk);
    #1;
    check_output("row1_load", load, 1);
    @(negedge clk);
    #1;
    check_output("no_queued_go", set, 0);

    // Rows 1,2 clean, row 3 lost
    lock_row(1'b0, 1);
    lock_row(1'b0, 2);
    lock_row(1'b1, 3);
    @(negedge clk);
    #1;
    check_output("lost_held", lost, 1);
    check_output("lost_row", row_sel, 3);
    check_output("lost_shift", shift_en, 0);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    #1;
    check_output("restart_lost_clr", lost, 0);
    check_output("restart_row0", row_sel, 0);
    @(negedge clk);
    #1;
    check_output("restart_load", load, 1);

    // Eight clean locks, checking top-row tick spacing before the last
    for (int r = 0; r < NUM_ROWS - 1; r++) begin
      lock_row(1'b0, r);
    end
    for (int k = 2; k <= 17; k++) begin
      @(negedge clk);
      #1;
      check_output($sformatf("r7_shift_k%0d", k), shift_en, (k % LAST_PERIOD) == 0);
    end
    lock_row(1'b0, NUM_ROWS - 1);
    @(negedge clk);
    #1;
    check_output("won_held", won, 1);
    check_output("won_shift", shift_en, 0);

    // Button held through reset must not lock
    reset = 1'b0;
    #1;
    check_output("rst_clears_won", won, 0);
    check_output("rst_row_again", row_sel, 0);
    go = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check_output("held_go_load", load, 1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      check_output($sformatf("held_go_no_set%0d", k), set, 0);
    end
    go = 1'b0;
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    #1;
    check_output("repress_set", set, 1);

    // Reset during LOCK clears everything at once
    reset = 1'b0;
    #1;
    check_output("midlock_set", set, 0);
    check_output("midlock_shift", shift_en, 0);
    check_output("midlock_won", won, 0);
    check_output("midlock_lost", lost, 0);
    check_output("midlock_load", load, 0);
    go = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check_output("midlock_reload", load, 1);
    check_output("midlock_row0", row_sel, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
